// File: rtl/gate_check_pkg.sv
// Shared types and truth tables for the two-input gate library checker.
// Bit i of each EXP_TABLE row is the expected gate output for vector {a,b} = i.
package gate_check_pkg;

   typedef enum logic [2:0] {
      GateOr   = 3'd0,
      GateAnd  = 3'd1,
      GateNot  = 3'd2,
      GateNand = 3'd3,
      GateNor  = 3'd4,
      GateXor  = 3'd5,
      GateXnor = 3'd6,
      GateRsvd = 3'd7
   } gate_sel_e;

   typedef enum logic [1:0] {
      StIdle,
      StSettle,
      StSample,
      StDone
   } state_e;

   localparam int unsigned NUM_VECS = 4;

   localparam logic [3:0] EXP_TABLE [0:7] = '{
      4'b1110,  // OR
      4'b1000,  // AND
      4'b0011,  // NOT (a only)
      4'b0111,  // NAND
      4'b0001,  // NOR
      4'b0110,  // XOR
      4'b1001,  // XNOR
      4'b0000   // reserved
   };

   function automatic logic exp_bit(gate_sel_e sel, logic [1:0] vec);
      logic [3:0] row;
      row = EXP_TABLE[sel];
      return row[vec];
   endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational truth-table reference for one two-input gate evaluation.
module gate_ref_model
   import gate_check_pkg::*;
(
   input  logic [2:0] gate_sel,
   input  logic       a,
   input  logic       b,
   output logic       expected
);

   assign expected = exp_bit(gate_sel_e'(gate_sel), {a, b});

endmodule

// File: rtl/gate_truth_table_checker.sv
// Sweeps all four input vectors into a gate under test, compares each settled output
// against the selected gate's truth table and reports a fail mask and pass flag.
module gate_truth_table_checker
   import gate_check_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] gate_sel,
   input  logic       dut_y,
   output logic       stim_a,
   output logic       stim_b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_mask
);

   localparam logic [3:0] CntLast = 4'(SETTLE_CYCLES - 1);

   state_e     state;
   gate_sel_e  sel_q;
   logic [1:0] vec;
   logic [3:0] cnt;
   logic       exp_y;
   logic [3:0] mask_upd;

   gate_ref_model u_ref (
      .gate_sel (sel_q),
      .a        (vec[1]),
      .b        (vec[0]),
      .expected (exp_y)
   );

   // Stimulus is a pure decode of registered state, so it is glitch-free toward the gate.
   always_comb begin
      stim_a = 1'b0;
      stim_b = 1'b0;
      if (state == StSettle || state == StSample) begin
         stim_a = vec[1];
         stim_b = vec[0];
      end
   end

   always_comb begin
      mask_upd      = fail_mask;
      mask_upd[vec] = (dut_y != exp_y);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StIdle;
         sel_q     <= GateOr;
         vec       <= '0;
         cnt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail_mask <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            StIdle: begin
               if (start) begin
                  sel_q     <= gate_sel_e'(gate_sel);
                  vec       <= '0;
                  cnt       <= '0;
                  fail_mask <= '0;
                  pass      <= 1'b0;
                  busy      <= 1'b1;
                  state     <= StSettle;
               end
            end
            StSettle: begin
               if (sel_q == GateRsvd) begin
                  fail_mask <= 4'hF;
                  pass      <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= StDone;
               end else begin
                  cnt <= cnt + 4'd1;
                  if (cnt == CntLast) begin
                     state <= StSample;
                  end
               end
            end
            StSample: begin
               fail_mask <= mask_upd;
               if (vec == 2'd3) begin
                  // Result is committed on entry to DONE so it is valid during the pulse.
                  pass  <= (mask_upd == 4'd0);
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= StDone;
               end else begin
                  vec   <= vec + 2'd1;
                  cnt   <= '0;
                  state <= StSettle;
               end
            end
            StDone: begin
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Randomized scoreboard bench for gate_truth_table_checker with a rule-based gate model.
module tb_gate_truth_table_checker;

   localparam int S = 2;

   typedef struct {
      bit          pass;
      bit [3:0]    mask;
      int unsigned cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [2:0] gate_sel = 3'd0;
   logic       dut_y;
   logic       stim_a, stim_b, busy, done, pass;
   logic [3:0] fail_mask;

   int          kind = 0;
   bit [3:0]    flip = 4'd0;
   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_fails = 0;
   bit          held_pass = 1'b0;
   bit [3:0]    held_mask = 4'd0;
   exp_t        sb[$];

   gate_truth_table_checker #(.SETTLE_CYCLES(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .gate_sel  (gate_sel),
      .dut_y     (dut_y),
      .stim_a    (stim_a),
      .stim_b    (stim_b),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .fail_mask (fail_mask)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Gate behaviour from its boolean rule; kinds outside 0..6 behave as a stuck-at-0 output.
   function automatic bit gate_fn(int g, bit a, bit b);
      case (g)
         0: return a | b;
         1: return a & b;
         2: return !a;
         3: return !(a & b);
         4: return !(a | b);
         5: return a ^ b;
         6: return !(a ^ b);
         default: return 1'b0;
      endcase
   endfunction

   always_comb dut_y = gate_fn(kind, stim_a, stim_b) ^ flip[{stim_a, stim_b}];

   function automatic bit [3:0] expect_mask(int sel, int k, bit [3:0] f);
      bit [3:0] m;
      if (sel == 7) return 4'hF;
      m = 4'd0;
      for (int i = 0; i < 4; i++) begin
         bit a, b;
         a = bit'((i / 2) % 2);
         b = bit'(i % 2);
         m[i] = (gate_fn(k, a, b) ^ f[i]) != gate_fn(sel, a, b);
      end
      return m;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: consumes the scoreboard on every done pulse and checks held results otherwise.
   always @(negedge clk) begin
      if (rst) begin
         held_pass = 1'b0;
         held_mask = 4'd0;
      end else begin
         if (!busy) check("stim_zero_when_idle", {stim_a, stim_b}, 2'b00);
         if (done) begin
            check("done_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               check("pass", pass, e.pass);
               check("fail_mask", fail_mask, e.mask);
               check("done_cycle", cyc, e.cyc);
               check("busy_low_in_done", busy, 0);
               held_pass = e.pass;
               held_mask = e.mask;
            end
         end else if (!busy) begin
            check("pass_held", pass, held_pass);
            check("mask_held", fail_mask, held_mask);
         end
      end
   end

   // Called at a negedge with the DUT in IDLE; returns at the negedge after the accepting edge.
   task automatic launch(input int sel);
      exp_t e;
      e.mask = expect_mask(sel, kind, flip);
      e.pass = (e.mask == 4'd0);
      e.cyc  = cyc + 1 + ((sel == 7) ? 1 : 4 * (S + 1));
      sb.push_back(e);
      start    = 1'b1;
      gate_sel = 3'(sel);
      @(posedge clk);
      #1;
      check("busy_on_accept", busy, 1);
      check("stim_vec0_on_accept", {stim_a, stim_b}, 2'b00);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 200; i++) begin
         if (done) break;
         @(negedge clk);
      end
      check("done_within_bound", done, 1);
      @(negedge clk);
   endtask

   task automatic run(input int sel, input int k, input bit [3:0] f);
      kind = k;
      flip = f;
      launch(sel);
      wait_done();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_mask", fail_mask, 0);
      check("rst_stim", {stim_a, stim_b}, 2'b00);
      @(negedge clk);

      run(1, 1, 4'd0);   // AND vs correct AND
      run(5, 0, 4'd0);   // XOR vs OR
      run(2, 2, 4'd0);   // NOT vs ~a
      run(2, 7, 4'd0);   // NOT vs stuck-at-0
      run(7, 1, 4'd0);   // reserved
      run(6, 6, 4'b0101);

      // Reset during vector 2 aborts with no done pulse.
      kind = 7;
      flip = 4'd0;
      launch(4);
      repeat (7) @(negedge clk);
      check("mask_before_abort", fail_mask, 4'b0001);
      rst = 1'b1;
      void'(sb.pop_back());
      @(posedge clk);
      #1;
      check("abort_busy", busy, 0);
      check("abort_mask", fail_mask, 0);
      check("abort_done", done, 0);
      check("abort_stim", {stim_a, stim_b}, 2'b00);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      run(0, 0, 4'd0);

      // start and gate_sel toggled while busy are ignored.
      kind = 3;
      flip = 4'd0;
      launch(3);
      for (int i = 0; i < 6; i++) begin
         gate_sel = 3'($urandom_range(0, 7));
         start    = i[0];
         @(negedge clk);
      end
      start = 1'b0;
      wait_done();
      repeat (20) @(negedge clk);

      // start held high: back-to-back runs with a one-cycle busy gap.
      begin
         exp_t e1, e2;
         kind    = 5;
         flip    = 4'b0010;
         e1.mask = expect_mask(5, kind, flip);
         e1.pass = (e1.mask == 4'd0);
         e1.cyc  = cyc + 1 + 4 * (S + 1);
         e2      = e1;
         e2.cyc  = e1.cyc + 2 + 4 * (S + 1);
         sb.push_back(e1);
         sb.push_back(e2);
         start    = 1'b1;
         gate_sel = 3'd5;
         wait_done();
         check("gap_busy_low", busy, 0);
         @(posedge clk);
         #1;
         check("restart_busy", busy, 1);
         @(negedge clk);
         start = 1'b0;
         wait_done();
      end

      for (int n = 0; n < 40; n++) begin
         int sel, k;
         bit [3:0] f;
         sel = $urandom_range(0, 7);
         k   = ($urandom_range(0, 1) == 1) ? sel : $urandom_range(0, 7);
         f   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
         run(sel, k, f);
      end

      repeat (5) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/gate_truth_table_checker.md
# gate_truth_table_checker

Self-checking response block for the two-input logic-gate library: on `start`, it sweeps all four input vectors into a gate under test and samples the gate's output after a settle interval. It compares each sample against the truth table of the selected gate type and reports a per-vector fail mask and an overall pass flag. It is the consuming end of the gate stimulus interface, and it replaces hand-inspected waveform benches with a synthesizable checker that can sit beside any gate instance.

## Interface
- `SETTLE_CYCLES`, default 2: cycles that each vector is held before sampling. Legal range is 1..15; 0 is illegal.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begins a sweep when sampled high in IDLE.
- `gate_sel` in 3: 0 OR, 1 AND, 2 NOT, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 reserved.
- `dut_y` in 1: output of the gate under test.
- `stim_a` out 1: drives gate input a (and `in` for NOT).
- `stim_b` out 1: drives gate input b.
- `busy` out 1: high from the edge accepting `start` until the run completes.
- `done` out 1: one-cycle pulse at the end of each run.
- `pass` out 1: run result, held until the next accepted `start`.
- `fail_mask` out 4: bit i set means vector i mismatched; held like `pass`.

## Operation
- Vector order is i = 0..3 with {a,b} = i: 00, 01, 10, 11.
- Expected `dut_y` per gate, listed for vectors 0,1,2,3:
  - OR 0,1,1,1
  - AND 0,0,0,1
  - NOT (uses a only) 1,1,0,0
  - NAND 1,1,1,0
  - NOR 1,0,0,0
  - XOR 0,1,1,0
  - XNOR 1,0,0,1
- FSM states are IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - On `start`=1: latch `gate_sel`, set vec=0, cnt=0, clear `fail_mask` and `pass`, then go to SETTLE.
  - If the latched `gate_sel`=7: set `fail_mask`=4'hF and go directly to DONE without a sweep.
- SETTLE:
  - `stim_a`/`stim_b` = vec.
  - cnt increments each cycle; when cnt==SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE (one cycle):
  - `fail_mask[vec]` <= (`dut_y` != expected).
  - If vec==3, go to DONE; otherwise increment vec, set cnt=0, and go to SETTLE.
- DONE (one cycle):
  - `done`=1, `busy`=0, `pass` <= (`fail_mask`==0), using the fully updated mask.
  - Then go to IDLE.
- `start` is ignored outside IDLE; `gate_sel` changes during a run are ignored.
- `stim_a`/`stim_b` are 0 whenever the state is not SETTLE or SAMPLE.

## Timing
- Reset values: `stim_a`=0, `stim_b`=0, `busy`=0, `done`=0, `pass`=0, `fail_mask`=0; state IDLE, vec=0, cnt=0.
- `rst` mid-run aborts at the next edge and restores all reset values; no `done` pulse is issued.
- `rst` and `start` high in the same cycle: `rst` wins.
- `start` accepted at edge k:
  - `busy` and vector 0 stimulus are visible from edge k onward.
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - `dut_y` is sampled in the last cycle of each vector.
  - `done` is high for exactly one cycle, beginning at edge k+4·(SETTLE_CYCLES+1).
- Reserved `gate_sel`: `done` is high in the cycle after edge k+1, with `pass`=0.
- `pass` and `fail_mask` are valid from the `done` cycle and stable until the next accepted `start`.
- `start` held high continuously: a new run starts in the first IDLE cycle after DONE, giving a one-cycle gap with `busy`=0.
- `dut_y` is treated as combinational relative to the stimulus; a gate with more than SETTLE_CYCLES of latency fails by design.

## Structure
- Shared package `gate_check_pkg`:
  - `gate_sel_e` encoding (OR..XNOR, RSVD).
  - `EXP_TABLE` constant: a 4-bit expected pattern per gate, indexed by vec.
  - FSM state enum.
- One natural sub-module: `gate_ref_model` (combinational; inputs `gate_sel`, a, b; output expected). Reusable in other benches.
- Remaining sequential logic (FSM, vec/cnt counters, result registers) stays in the top module.

## Test plan
1. Reset, then `start` with `gate_sel`=1 and `dut_y` wired to a correct AND, SETTLE_CYCLES=2 → `done` at cycle 12 after start, `pass`=1, `fail_mask`=0000.
2. `gate_sel`=5 with `dut_y` wired to an OR gate → `fail_mask`=4'b1000 (vector 3 only), `pass`=0.
3. `gate_sel`=2 with `dut_y` wired as ~`stim_a` → `pass`=1. Repeat with `dut_y` tied to 0 → `fail_mask`=4'b0011.
4. `gate_sel`=7 → `done` one cycle after start, `fail_mask`=4'hF, `pass`=0, `stim_a`/`stim_b` stay 0.
5. Assert `rst` during vector 2 → next edge `busy`=0, `fail_mask`=0, no `done`. A fresh `start` then completes normally.
6. Pulse `start` and toggle `gate_sel` while `busy` → no restart, result matches the originally latched gate, exactly one `done` pulse.
